// File: rtl/enable_seq_pkg.sv
// Shared definitions for the staged-enable sequencer: state encoding,
// default geometry and the thermometer mask helper.
package enable_seq_pkg;

   localparam int N_STAGES_DEF = 4;
   localparam int HOLD_W_DEF   = 4;
   localparam int REP_W_DEF    = 4;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARM  = 3'd1,
      S_STEP = 3'd2,
      S_GAP  = 3'd3,
      S_DONE = 3'd4
   } state_e;

   // Step k enables stage k and every stage above it.
   function automatic logic [N_STAGES_DEF-1:0] therm_mask(input int k);
      logic [N_STAGES_DEF-1:0] m;
      m = '1;
      return m << k;
   endfunction

endpackage

// File: rtl/enable_sequencer_if.sv
// Control/status bundle between the test logic and the enable sequencer.
interface enable_sequencer_if
   import enable_seq_pkg::*;
#(
   parameter int N_STAGES = N_STAGES_DEF,
   parameter int HOLD_W   = HOLD_W_DEF,
   parameter int REP_W    = REP_W_DEF,
   parameter int STEP_W   = $clog2(N_STAGES)
);

   logic                start;
   logic                abort;
   logic [HOLD_W-1:0]   hold_cycles;
   logic [REP_W-1:0]    repeat_cnt;
   logic                trg;
   logic [N_STAGES-1:0] ena;
   logic                busy;
   logic                done;
   logic [STEP_W-1:0]   step_idx;
   logic [REP_W-1:0]    round_idx;

   modport master (
      output start, abort, hold_cycles, repeat_cnt,
      input  trg, ena, busy, done, step_idx, round_idx
   );

   modport slave (
      input  start, abort, hold_cycles, repeat_cnt,
      output trg, ena, busy, done, step_idx, round_idx
   );

endinterface

// File: rtl/enable_therm_mask.sv
// Combinational step index to thermometer enable mask decoder.
module enable_therm_mask #(
   parameter int N_STAGES = 4,
   parameter int STEP_W   = $clog2(N_STAGES)
) (
   input  logic [STEP_W-1:0]   k,
   output logic [N_STAGES-1:0] mask
);

   logic [N_STAGES-1:0] ones;

   assign ones = '1;
   assign mask = ones << k;

endmodule

// File: rtl/enable_sequencer.sv
// Sequences trg and a shrinking thermometer enable mask over a programmable
// number of hold cycles per step and rounds per run.
//
//  state | meaning
//  IDLE  | waiting for start; counters cleared
//  ARM   | one cycle, trg high, mask off
//  STEP  | mask step k held for hold+1 cycles
//  GAP   | one cycle between rounds, trg high, mask off
//  DONE  | one-cycle done pulse, then IDLE
module enable_sequencer
   import enable_seq_pkg::*;
#(
   parameter int N_STAGES = N_STAGES_DEF,
   parameter int HOLD_W   = HOLD_W_DEF,
   parameter int REP_W    = REP_W_DEF,
   parameter int STEP_W   = $clog2(N_STAGES)
) (
   input  logic               clk,
   input  logic               rst_n,
   enable_sequencer_if.slave  bus
);

   localparam logic [STEP_W-1:0] K_LAST = STEP_W'(N_STAGES - 1);

   state_e              state_q, state_d;
   logic [STEP_W-1:0]   k_q, k_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [HOLD_W-1:0]   hold_lat_q, hold_lat_d;
   logic [REP_W-1:0]    rep_lat_q, rep_lat_d;
   logic [REP_W-1:0]    round_q, round_d;
   logic                trg_q, trg_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [N_STAGES-1:0] ena_q, ena_d;
   logic [N_STAGES-1:0] mask_d;
   logic                running;

   enable_therm_mask #(
      .N_STAGES (N_STAGES),
      .STEP_W   (STEP_W)
   ) u_mask (
      .k    (k_d),
      .mask (mask_d)
   );

   assign running = (state_q == S_ARM) || (state_q == S_STEP) || (state_q == S_GAP);

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      hold_cnt_d = hold_cnt_q;
      hold_lat_d = hold_lat_q;
      rep_lat_d  = rep_lat_q;
      round_d    = round_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.abort) begin
               hold_lat_d = bus.hold_cycles;
               rep_lat_d  = bus.repeat_cnt;
               state_d    = S_ARM;
            end
         end
         S_ARM, S_GAP: begin
            state_d    = S_STEP;
            k_d        = '0;
            hold_cnt_d = '0;
         end
         S_STEP: begin
            if (hold_cnt_q == hold_lat_q) begin
               hold_cnt_d = '0;
               if (k_q == K_LAST) begin
                  k_d = '0;
                  if (round_q == rep_lat_q) begin
                     state_d = S_DONE;
                  end else begin
                     round_d = round_q + 1'b1;
                     state_d = S_GAP;
                  end
               end else begin
                  k_d = k_q + 1'b1;
               end
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            round_d = '0;
         end
         default: begin
            state_d = S_IDLE;
            k_d     = '0;
            round_d = '0;
         end
      endcase

      // Abort cuts a run short without a done pulse; DONE finishes regardless.
      if (bus.abort && running) begin
         state_d    = S_IDLE;
         k_d        = '0;
         hold_cnt_d = '0;
         round_d    = '0;
      end

      trg_d  = (state_d == S_ARM) || (state_d == S_STEP) || (state_d == S_GAP);
      busy_d = trg_d;
      done_d = (state_d == S_DONE);
      ena_d  = (state_d == S_STEP) ? mask_d : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         k_q        <= '0;
         hold_cnt_q <= '0;
         hold_lat_q <= '0;
         rep_lat_q  <= '0;
         round_q    <= '0;
         trg_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ena_q      <= '0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         hold_cnt_q <= hold_cnt_d;
         hold_lat_q <= hold_lat_d;
         rep_lat_q  <= rep_lat_d;
         round_q    <= round_d;
         trg_q      <= trg_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ena_q      <= ena_d;
      end
   end

   assign bus.trg       = trg_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.ena       = ena_q;
   assign bus.step_idx  = k_q;
   assign bus.round_idx = round_q;

endmodule

// File: tb/tb_enable_sequencer.sv
// Randomized scoreboard bench for enable_sequencer against a run-plan model.
module tb_enable_sequencer;

   typedef struct packed {
      logic       trg;
      logic [3:0] ena;
      logic       busy;
      logic       done;
      logic [1:0] step;
      logic [3:0] round;
   } out_t;

   logic clk;
   logic rst_n;

   enable_sequencer_if #(.N_STAGES(4), .HOLD_W(4), .REP_W(4)) bus ();

   enable_sequencer #(.N_STAGES(4), .HOLD_W(4), .REP_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   vectors;
   int   miscompares;
   int   cyc;
   out_t exp_q[$];
   out_t plan[$];
   out_t cur;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic out_t mk(input int trg, input int ena, input int busy,
                               input int done, input int step, input int round);
      out_t o;
      o.trg   = 1'(trg);
      o.ena   = 4'(ena);
      o.busy  = 1'(busy);
      o.done  = 1'(done);
      o.step  = 2'(step);
      o.round = 4'(round);
      return o;
   endfunction

   function automatic out_t sample();
      out_t o;
      o.trg   = bus.trg;
      o.ena   = bus.ena;
      o.busy  = bus.busy;
      o.done  = bus.done;
      o.step  = bus.step_idx;
      o.round = bus.round_idx;
      return o;
   endfunction

   // Whole run as a list of per-cycle outputs: ARM, rounds of 4 steps, GAPs, DONE.
   task automatic build_plan(input int h, input int r);
      plan.push_back(mk(1, 0, 1, 0, 0, 0));
      for (int rd = 0; rd <= r; rd++) begin
         if (rd > 0) plan.push_back(mk(1, 0, 1, 0, 0, rd));
         for (int k = 0; k < 4; k++)
            for (int c = 0; c <= h; c++)
               plan.push_back(mk(1, 16 - (1 << k), 1, 0, k, rd));
      end
      plan.push_back(mk(0, 0, 0, 1, 0, r));
   endtask

   task automatic cycle(input bit st, input bit ab, input int h, input int r);
      out_t nxt;
      @(negedge clk);
      bus.start       = st;
      bus.abort       = ab;
      bus.hold_cycles = 4'(h);
      bus.repeat_cnt  = 4'(r);
      if (cur.busy && ab) begin
         plan.delete();
         nxt = '0;
      end else if (plan.size() > 0) begin
         nxt = plan.pop_front();
      end else if (!cur.busy && !cur.done && st && !ab) begin
         build_plan(h, r);
         nxt = plan.pop_front();
      end else begin
         nxt = '0;
      end
      cur = nxt;
      exp_q.push_back(nxt);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0);
   endtask

   task automatic check_zero(input string name);
      out_t got;
      got = sample();
      vectors++;
      if (got !== out_t'(0)) begin
         miscompares++;
         $display("FAIL %s: got %h required 0", name, got);
      end
   endtask

   initial begin : monitor
      out_t e;
      out_t got;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = sample();
            vectors++;
            if (got !== e) begin
               miscompares++;
               $display("FAIL out_cycle%0d: got trg=%b ena=%b busy=%b done=%b step=%0d round=%0d, required trg=%b ena=%b busy=%b done=%b step=%0d round=%0d",
                        cyc, got.trg, got.ena, got.busy, got.done, got.step, got.round,
                        e.trg, e.ena, e.busy, e.done, e.step, e.round);
            end
         end
      end
   end

   initial begin : stim
      int h;
      int r;
      vectors         = 0;
      miscompares     = 0;
      cyc             = 0;
      cur             = '0;
      rst_n           = 1'b0;
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.hold_cycles = '0;
      bus.repeat_cnt  = '0;
      repeat (3) @(negedge clk);
      check_zero("reset_state");
      rst_n = 1'b1;
      idle(2);

      cycle(1'b1, 1'b0, 0, 0);
      idle(8);

      cycle(1'b1, 1'b0, 2, 1);
      idle(30);

      cycle(1'b1, 1'b0, 2, 0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 2, 0);
      cycle(1'b0, 1'b1, 2, 0);
      cycle(1'b1, 1'b0, 1, 0);
      idle(12);

      for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1, 1);
      idle(5);

      cycle(1'b1, 1'b0, 3, 1);
      for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, $urandom_range(15), $urandom_range(15));

      cycle(1'b1, 1'b0, 15, 0);
      idle(70);

      cycle(1'b1, 1'b0, 3, 0);
      idle(6);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("async_reset_mid_step");
      exp_q.delete();
      plan.delete();
      cur = '0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(4);

      for (int i = 0; i < 3000; i++) begin
         h = ($urandom_range(3) == 0) ? $urandom_range(15) : $urandom_range(2);
         r = $urandom_range(3);
         cycle($urandom_range(7) == 0, $urandom_range(49) == 0, h, r);
      end
      idle(3);
      @(posedge clk);
      #2;
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
